// File: rtl/cmd_cfg.sv
// cmd_cfg: turns received commands into flight setpoints, motor-disable flag and
// the inertial calibration sequence, acknowledging each with a one-byte response.
module cmd_cfg #(
    parameter bit FAST_SIM = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_rdy,
    input  logic [7:0]         cmd,
    input  logic [15:0]        data,
    input  logic               cal_done,
    output logic               clr_cmd_rdy,
    output logic [7:0]         resp,
    output logic               send_resp,
    output logic signed [15:0] d_ptch,
    output logic signed [15:0] d_roll,
    output logic signed [15:0] d_yaw,
    output logic [8:0]         thrst,
    output logic               strt_cal,
    output logic               inertial_cal,
    output logic               motors_off
);
    localparam int TW = FAST_SIM ? 9 : 26;
    localparam logic [7:0] SET_PTCH  = 8'h02;
    localparam logic [7:0] SET_ROLL  = 8'h03;
    localparam logic [7:0] SET_YAW   = 8'h04;
    localparam logic [7:0] SET_THRST = 8'h05;
    localparam logic [7:0] CALIBRATE = 8'h06;
    localparam logic [7:0] EMER_LAND = 8'h07;
    localparam logic [7:0] MTRS_OFF  = 8'h08;
    localparam logic [7:0] ACK_POS   = 8'hA5;
    localparam logic [7:0] ACK_NEG   = 8'hEE;

    typedef enum logic [1:0] {IDLE, CAL_SPIN, CAL_WAIT, ACK} state_t;

    state_t      state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [15:0] ptch_q, ptch_d, roll_q, roll_d, yaw_q, yaw_d;
    logic [8:0]  thrst_q, thrst_d;
    logic [7:0]  resp_q, resp_d;
    logic        mo_q, mo_d;
    logic        legal, land;

    assign legal = (cmd >= SET_PTCH) && (cmd <= MTRS_OFF);
    assign land  = cmd == EMER_LAND;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        ptch_d  = ptch_q;
        roll_d  = roll_q;
        yaw_d   = yaw_q;
        thrst_d = thrst_q;
        resp_d  = resp_q;
        mo_d    = mo_q;
        case (state_q)
            IDLE: if (cmd_rdy) begin
                if (cmd == CALIBRATE) begin
                    mo_d    = 1'b0;
                    tmr_d   = '0;
                    state_d = CAL_SPIN;
                end else begin
                    state_d = ACK;
                    resp_d  = legal ? ACK_POS : ACK_NEG;
                    ptch_d  = cmd == SET_PTCH ? data : land ? 16'h0 : ptch_q;
                    roll_d  = cmd == SET_ROLL ? data : land ? 16'h0 : roll_q;
                    yaw_d   = cmd == SET_YAW ? data : land ? 16'h0 : yaw_q;
                    thrst_d = cmd == SET_THRST ? data[8:0] : land ? 9'h0 : thrst_q;
                    mo_d    = cmd == MTRS_OFF ? 1'b1 : mo_q;
                end
            end
            CAL_SPIN: begin
                tmr_d   = tmr_q + 1'b1;
                state_d = &tmr_q ? CAL_WAIT : CAL_SPIN;
            end
            CAL_WAIT: if (cal_done) begin
                state_d = ACK;
                resp_d  = ACK_POS;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            ptch_q  <= '0;
            roll_q  <= '0;
            yaw_q   <= '0;
            thrst_q <= '0;
            resp_q  <= '0;
            mo_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            ptch_q  <= ptch_d;
            roll_q  <= roll_d;
            yaw_q   <= yaw_d;
            thrst_q <= thrst_d;
            resp_q  <= resp_d;
            mo_q    <= mo_d;
        end
    end

    // Pulses decode straight from registered state so they land in the same cycle
    assign clr_cmd_rdy  = (state_q == IDLE) && cmd_rdy;
    assign strt_cal     = (state_q == CAL_SPIN) && (&tmr_q);
    assign send_resp    = state_q == ACK;
    assign inertial_cal = (state_q == CAL_SPIN) || (state_q == CAL_WAIT);
    assign resp         = resp_q;
    assign d_ptch       = ptch_q;
    assign d_roll       = roll_q;
    assign d_yaw        = yaw_q;
    assign thrst        = thrst_q;
    assign motors_off   = mo_q;
endmodule

// File: tb/tb_cmd_cfg.sv
// tb_cmd_cfg: table-driven command vectors with a response scoreboard, plus
// hand-written calibration, pending-command and mid-sequence reset cases.
module tb_cmd_cfg;
    logic clk = 1'b0, rst = 1'b1, cmd_rdy = 1'b0, cal_done = 1'b0;
    logic [7:0] cmd = '0;
    logic [15:0] data = '0;
    logic clr_cmd_rdy, send_resp, strt_cal, inertial_cal, motors_off;
    logic [7:0] resp;
    logic signed [15:0] d_ptch, d_roll, d_yaw;
    logic [8:0] thrst;

    cmd_cfg #(.FAST_SIM(1'b1)) dut (
        .clk(clk), .rst(rst), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
        .cal_done(cal_done), .clr_cmd_rdy(clr_cmd_rdy), .resp(resp),
        .send_resp(send_resp), .d_ptch(d_ptch), .d_roll(d_roll), .d_yaw(d_yaw),
        .thrst(thrst), .strt_cal(strt_cal), .inertial_cal(inertial_cal),
        .motors_off(motors_off)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] data;
        logic [7:0]  resp;
        logic [15:0] p, r, y;
        logic [8:0]  t;
        logic        mo;
    } vec_t;

    vec_t tbl[13];
    logic [7:0] exp_q[$];
    int passed = 0, total = 0;
    logic prev_send = 1'b0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, a, e, $time);
    endtask

    task automatic chk_regs(input string n, input vec_t v);
        chk({n, "_ptch"}, {16'h0, d_ptch}, {16'h0, v.p});
        chk({n, "_roll"}, {16'h0, d_roll}, {16'h0, v.r});
        chk({n, "_yaw"}, {16'h0, d_yaw}, {16'h0, v.y});
        chk({n, "_thrst"}, {23'h0, thrst}, {23'h0, v.t});
        chk({n, "_mo"}, {31'h0, motors_off}, {31'h0, v.mo});
    endtask

    always @(negedge clk) begin
        if (send_resp) begin
            chk("no_back_to_back", {31'h0, prev_send}, 32'h0);
            if (exp_q.size() == 0) chk("unexpected_resp", {24'h0, resp}, 32'hFFFF_FFFF);
            else chk("sb_resp", {24'h0, resp}, {24'h0, exp_q.pop_front()});
        end
        prev_send = send_resp;
    end

    task automatic do_vec(input int i);
        exp_q.push_back(tbl[i].resp);
        @(negedge clk);
        cmd = tbl[i].cmd; data = tbl[i].data; cmd_rdy = 1'b1;
        #1 chk($sformatf("v%0d_clr", i), {31'h0, clr_cmd_rdy}, 32'h1);
        @(posedge clk); #1 cmd_rdy = 1'b0;
        chk($sformatf("v%0d_send", i), {31'h0, send_resp}, 32'h1);
        chk_regs($sformatf("v%0d", i), tbl[i]);
        @(posedge clk); #1 chk($sformatf("v%0d_send_end", i), {31'h0, send_resp}, 32'h0);
    endtask

    task automatic do_cal(input bit inj);
        int n;
        bit seen;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        cmd = 8'h06; data = 16'h0; cmd_rdy = 1'b1;
        #1 chk("cal_clr", {31'h0, clr_cmd_rdy}, 32'h1);
        @(posedge clk); #1 cmd_rdy = 1'b0;
        chk("cal_mo", {31'h0, motors_off}, 32'h0);
        chk("cal_ic", {31'h0, inertial_cal}, 32'h1);
        n = 0;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            cal_done = (i == 10);
            n = i;
            if (strt_cal) break;
        end
        cal_done = 1'b0;
        chk("strt_dly", n, 512);
        if (inj) begin
            exp_q.push_back(8'hA5);
            cmd = 8'h04; data = 16'h7777; cmd_rdy = 1'b1;
        end
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            #1 if (send_resp || clr_cmd_rdy || strt_cal) seen = 1'b1;
        end
        chk("wait_quiet", {31'h0, seen}, 32'h0);
        chk("wait_ic", {31'h0, inertial_cal}, 32'h1);
        if (inj) chk("yaw_hold", {16'h0, d_yaw}, 32'h0);
        cal_done = 1'b1;
        @(posedge clk); #1 cal_done = 1'b0;
        chk("cal_ack", {31'h0, send_resp}, 32'h1);
        chk("cal_ic_off", {31'h0, inertial_cal}, 32'h0);
        @(posedge clk); #1;
        if (inj) begin
            chk("pend_clr", {31'h0, clr_cmd_rdy}, 32'h1);
            @(posedge clk); #1 cmd_rdy = 1'b0;
            chk("pend_yaw", {16'h0, d_yaw}, 32'h7777);
            chk("pend_send", {31'h0, send_resp}, 32'h1);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_rst_spin();
        bit seen;
        @(negedge clk);
        cmd = 8'h06; cmd_rdy = 1'b1;
        @(posedge clk); #1 cmd_rdy = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_ic", {31'h0, inertial_cal}, 32'h0);
        chk("rst_mo", {31'h0, motors_off}, 32'h1);
        chk("rst_yaw", {16'h0, d_yaw}, 32'h0);
        chk("rst_resp", {24'h0, resp}, 32'h0);
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        repeat (600) begin
            @(negedge clk);
            if (strt_cal || send_resp || inertial_cal) seen = 1'b1;
        end
        chk("rst_no_resume", {31'h0, seen}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{8'h02, 16'hFF38, 8'hA5, 16'hFF38, 16'h0000, 16'h0000, 9'h000, 1'b1};
        tbl[1]  = '{8'h03, 16'h0064, 8'hA5, 16'hFF38, 16'h0064, 16'h0000, 9'h000, 1'b1};
        tbl[2]  = '{8'h04, 16'h8000, 8'hA5, 16'hFF38, 16'h0064, 16'h8000, 9'h000, 1'b1};
        tbl[3]  = '{8'h05, 16'h01FF, 8'hA5, 16'hFF38, 16'h0064, 16'h8000, 9'h1FF, 1'b1};
        tbl[4]  = '{8'h05, 16'hFE05, 8'hA5, 16'hFF38, 16'h0064, 16'h8000, 9'h005, 1'b1};
        tbl[5]  = '{8'h55, 16'h1234, 8'hEE, 16'hFF38, 16'h0064, 16'h8000, 9'h005, 1'b1};
        tbl[6]  = '{8'h06, 16'h0000, 8'hA5, 16'hFF38, 16'h0064, 16'h8000, 9'h005, 1'b0};
        tbl[7]  = '{8'h02, 16'h0010, 8'hA5, 16'h0010, 16'h0064, 16'h8000, 9'h005, 1'b0};
        tbl[8]  = '{8'h05, 16'h0040, 8'hA5, 16'h0010, 16'h0064, 16'h8000, 9'h040, 1'b0};
        tbl[9]  = '{8'h07, 16'hFFFF, 8'hA5, 16'h0000, 16'h0000, 16'h0000, 9'h000, 1'b0};
        tbl[10] = '{8'h08, 16'h0000, 8'hA5, 16'h0000, 16'h0000, 16'h0000, 9'h000, 1'b1};
        tbl[11] = '{8'h00, 16'hABCD, 8'hEE, 16'h0000, 16'h0000, 16'h0000, 9'h000, 1'b1};
        tbl[12] = '{8'hFF, 16'h5A5A, 8'hEE, 16'h0000, 16'h0000, 16'h0000, 9'h000, 1'b1};
        repeat (3) @(negedge clk);
        chk_regs("reset", '{8'h0, 16'h0, 8'h0, 16'h0, 16'h0, 16'h0, 9'h0, 1'b1});
        chk("reset_resp", {24'h0, resp}, 32'h0);
        chk("reset_pulses", {28'h0, send_resp, clr_cmd_rdy, strt_cal, inertial_cal}, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].cmd == 8'h06) begin
                do_cal(1'b0);
                chk_regs($sformatf("v%0d", i), tbl[i]);
            end else do_vec(i);
        end
        do_cal(1'b1);
        do_rst_spin();
        chk("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
